// File: rtl/ga_pkg.sv
// ga_pkg: shared widths, distance sentinel and sweep FSM states for the GA TSP engine
package ga_pkg;
  localparam int GENE_W = 10;
  localparam int GENES = 15;
  localparam int CHROM_W = GENE_W * GENES;
  localparam int DIST_W = 12;
  localparam logic [DIST_W-1:0] DIST_MAX = 12'hFFF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } sweep_state_t;
endpackage

// File: rtl/min_tracker.sv
// min_tracker: keeps the strictly-smallest distance and its index (clk, rst, clear, en, val, idx -> best_dist, best_idx)
module min_tracker
  import ga_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DIST_W-1:0] val,
  input  logic [ADDR_W-1:0] idx,
  output logic [DIST_W-1:0] best_dist,
  output logic [ADDR_W-1:0] best_idx
);
  always_ff @(posedge clk)
    if (rst || clear) begin
      best_dist <= DIST_MAX;
      best_idx <= '0;
    end else if (en && val < best_dist) begin
      best_dist <= val;
      best_idx <= idx;
    end
endmodule

// File: rtl/fitness_sweep.sv
// fitness_sweep: on go, reads each chromosome, runs it through CompDistance (start/done handshake with timeout), writes fitness RAM and tracks the best tour; outputs busy/done/timeout_err
module fitness_sweep
  import ga_pkg::*;
#(
  parameter int POP_SIZE = 32,
  parameter int ADDR_W = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               pop_re,
  output logic [ADDR_W-1:0]  pop_addr,
  input  logic [CHROM_W-1:0] pop_data,
  output logic [CHROM_W-1:0] dist_in,
  output logic               dist_start,
  input  logic [DIST_W-1:0]  dist_out,
  input  logic               dist_done,
  output logic               fit_we,
  output logic [ADDR_W-1:0]  fit_addr,
  output logic [DIST_W-1:0]  fit_data,
  output logic [ADDR_W-1:0]  best_idx,
  output logic [DIST_W-1:0]  best_dist,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  sweep_state_t state, state_n;
  logic [ADDR_W-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DIST_W-1:0] val;
  logic last, expire, start_sweep;
  assign last = idx == ADDR_W'(POP_SIZE - 1);
  assign expire = cnt == CW'(TIMEOUT - 1);
  assign start_sweep = state == S_IDLE && go;
  assign pop_re = state == S_READ;
  assign dist_start = state == S_LAUNCH;
  assign fit_we = state == S_WRITE;
  assign done = state == S_FINISH;
  assign busy = state != S_IDLE;
  assign pop_addr = idx;
  assign fit_addr = idx;
  assign fit_data = val;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      val <= '0;
      dist_in <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (start_sweep) begin
        idx <= '0;
        timeout_err <= 1'b0;
      end
      if (state == S_WRITE && !last) idx <= idx + ADDR_W'(1);
      if (state == S_CAPTURE) dist_in <= pop_data;
      if (state == S_LAUNCH) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CW'(1);
      if (state == S_WAIT && dist_done) val <= dist_out;
      else if (state == S_WAIT && expire) begin
        val <= DIST_MAX;
        timeout_err <= 1'b1;
      end
    end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = go ? S_READ : S_IDLE;
      S_READ:    state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_LAUNCH;
      S_LAUNCH:  state_n = S_WAIT;
      S_WAIT:    state_n = (dist_done || expire) ? S_WRITE : S_WAIT;
      S_WRITE:   state_n = last ? S_FINISH : S_READ;
      default:   state_n = S_IDLE;
    endcase
  end
  min_tracker #(.ADDR_W(ADDR_W)) u_min (
    .clk(clk),
    .rst(rst),
    .clear(start_sweep),
    .en(state == S_WRITE),
    .val(val),
    .idx(idx),
    .best_dist(best_dist),
    .best_idx(best_idx)
  );
endmodule

// File: tb/tb_fitness_sweep.sv
// tb_fitness_sweep: directed bench for fitness_sweep with a population RAM and CompDistance reply model
module tb_fitness_sweep;
  logic clk = 0, rst = 1, go = 0;
  logic pop_re, dist_start, fit_we, busy, done, timeout_err, dist_done;
  logic [1:0] pop_addr, fit_addr, best_idx;
  logic [149:0] pop_data = '0, dist_in;
  logic [11:0] dist_out, fit_data, best_dist;
  logic [149:0] pop[4];
  logic [149:0] pat;
  int dly[4];
  int dv[4];
  int n_chk = 0, n_err = 0, cyc = 0;
  logic mclr = 0, spur = 0, act = 0;
  int since = 0, cur = 0, nst = 0;
  int wq_a[$], wq_d[$], wq_c[$];
  int n_start, n_done, done_cyc, first_re, re_addr, first_st, wide, pt_bad, pt_seen;
  fitness_sweep #(.POP_SIZE(4), .ADDR_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .pop_re(pop_re), .pop_addr(pop_addr), .pop_data(pop_data),
    .dist_in(dist_in), .dist_start(dist_start), .dist_out(dist_out), .dist_done(dist_done),
    .fit_we(fit_we), .fit_addr(fit_addr), .fit_data(fit_data), .best_idx(best_idx),
    .best_dist(best_dist), .busy(busy), .done(done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pop_re) pop_data <= pop[pop_addr];
  always @(posedge clk)
    if (mclr) begin
      act <= 0;
      nst <= 0;
    end else if (dist_start) begin
      act <= 1;
      since <= 1;
      cur <= nst;
      nst <= nst + 1;
    end else if (act) begin
      if (dist_done) act <= 0;
      since <= since + 1;
    end
  assign dist_done = spur | (act && dly[cur] != 0 && since == dly[cur]);
  assign dist_out = spur ? 12'd5 : 12'(dv[cur]);
  task automatic check(input string tag, input logic [149:0] got, input logic [149:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic sweep(input int spur_off, input bit hold, input int rst_off);
    int prev_st, pt_on;
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    n_start = 0; n_done = 0; done_cyc = -1; first_re = -1; re_addr = -1; first_st = -1;
    wide = 0; pt_bad = 0; pt_seen = 0; prev_st = 0; pt_on = 0;
    mclr = 1;
    @(negedge clk);
    mclr = 0;
    go = 1;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (pop_re && first_re < 0) begin first_re = k; re_addr = int'(pop_addr); end
      if (dist_start) begin
        n_start++;
        if (prev_st != 0) wide = 1;
        if (first_st < 0) first_st = k;
        if (n_start == 4) begin pt_on = 1; pt_seen++; end
      end
      prev_st = int'(dist_start);
      if (pt_on != 0 && dist_in !== pat) pt_bad++;
      if (fit_we) begin
        if (fit_addr == 2'd3) pt_on = 0;
        wq_a.push_back(int'(fit_addr));
        wq_d.push_back(int'(fit_data));
        wq_c.push_back(k);
      end
      if (done) begin n_done++; done_cyc = k; end
      if (rst_off > 0 && k == rst_off + 1) begin
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_best_dist", best_dist, 12'hFFF);
        check("rst_best_idx", best_idx, 0);
        check("rst_fit_we", fit_we, 0);
      end
      if (rst_off > 0 && k == rst_off) rst = 1;
      spur = (k == spur_off);
      go = hold && (n_done == 0 || k == done_cyc);
      if (n_done > 0 && k > done_cyc + 2) break;
      if (rst_off > 0 && k > rst_off + 25) break;
    end
    go = 0; spur = 0;
  endtask
  task automatic check_writes(input string tag, input int d0, input int d1, input int d2, input int d3);
    int exp_d[4];
    exp_d = '{d0, d1, d2, d3};
    check({tag, "_nwrites"}, wq_a.size(), 4);
    for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq_a[i], i);
      check($sformatf("%s_data%0d", tag, i), wq_d[i], exp_d[i]);
    end
  endtask
  initial begin
    pat = {15{10'b0000000110}};
    pop[0] = {15{10'h155}};
    pop[1] = {15{10'h2AA}};
    pop[2] = {15{10'h0F3}};
    pop[3] = pat;
    dly = '{5, 5, 5, 5};
    dv = '{300, 120, 120, 450};
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pop_re", pop_re, 0);
    check("reset_start", dist_start, 0);
    check("reset_fit_we", fit_we, 0);
    check("reset_terr", timeout_err, 0);
    check("reset_best_dist", best_dist, 12'hFFF);
    check("reset_best_idx", best_idx, 0);
    check("reset_dist_in", dist_in, 0);
    check("reset_addrs", {pop_addr, fit_addr}, 0);
    rst = 0;
    @(negedge clk);
    sweep(0, 0, 0);
    check_writes("nom", 300, 120, 120, 450);
    check("nom_best_idx", best_idx, 1);
    check("nom_best_dist", best_dist, 120);
    check("nom_ndone", n_done, 1);
    check("nom_done_cyc", done_cyc, 37);
    check("nom_pop_re_cyc", first_re, 1);
    check("nom_start_cyc", first_st, 3);
    check("nom_first_we_cyc", wq_c.size() > 0 ? wq_c[0] : -1, 9);
    check("nom_terr", timeout_err, 0);
    check("nom_busy_after", busy, 0);
    check("pass_seen", pt_seen, 1);
    check("pass_bad", pt_bad, 0);
    dly = '{5, 5, 0, 5};
    dv = '{300, 120, 999, 450};
    sweep(0, 0, 0);
    check_writes("tmo", 300, 120, 12'hFFF, 450);
    check("tmo_terr", timeout_err, 1);
    check("tmo_ndone", n_done, 1);
    check("tmo_best_dist", best_dist, 120);
    dly = '{3, 16, 3, 3};
    dv = '{200, 77, 300, 90};
    sweep(1, 0, 0);
    check_writes("edge", 200, 77, 300, 90);
    check("edge_terr", timeout_err, 0);
    check("edge_best_idx", best_idx, 1);
    check("edge_best_dist", best_dist, 77);
    dly = '{5, 5, 5, 5};
    dv = '{300, 120, 120, 450};
    sweep(0, 0, 14);
    check("rmid_nwrites", wq_a.size(), 1);
    check("rmid_ndone", n_done, 0);
    check("rmid_busy", busy, 0);
    sweep(0, 0, 0);
    check("restart_re_addr", re_addr, 0);
    check_writes("restart", 300, 120, 120, 450);
    check("restart_ndone", n_done, 1);
    sweep(0, 1, 0);
    check("hold_nstart", n_start, 4);
    check("hold_wide", wide, 0);
    check("hold_ndone", n_done, 1);
    check("hold_nwrites", wq_a.size(), 4);
    check("hold_busy_after", busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fitness_sweep.md
# fitness_sweep

Population-level driver for the `CompDistance` tour-distance unit in the genetic TSP engine. On `go`, the block walks every chromosome in the population RAM, presents each one to `CompDistance`, and collects the 12-bit distance. It writes that distance into the fitness RAM and tracks the shortest tour seen. It is the initiating end of the `in`/`start`/`out`/`done` handshake that `CompDistance` responds to.

## Interface
- `POP_SIZE`, default 32: number of chromosomes per sweep (≥2).
- `ADDR_W`, default 5: population/fitness address width; 2^ADDR_W ≥ POP_SIZE.
- `TIMEOUT`, default 1024: maximum cycles to wait for `dist_done`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  one-cycle start of a sweep; ignored while `busy`.
- `pop_re`  out  1  population RAM read enable.
- `pop_addr`  out  ADDR_W  population RAM address.
- `pop_data`  in  150  chromosome: 15 genes × 10 bits, read data 1 cycle after `pop_re`.
- `dist_in`  out  150  chromosome to `CompDistance.in`.
- `dist_start`  out  1  one-cycle pulse to `CompDistance.start`.
- `dist_out`  in  12  `CompDistance.out`.
- `dist_done`  in  1  `CompDistance.done`.
- `fit_we`  out  1  fitness RAM write enable.
- `fit_addr`  out  ADDR_W  fitness write address.
- `fit_data`  out  12  fitness value.
- `best_idx`  out  ADDR_W  index of the shortest tour this sweep.
- `best_dist`  out  12  shortest distance this sweep.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `timeout_err`  out  1  sticky; a chromosome timed out this sweep.

## Operation
- FSM states: IDLE → READ → CAPTURE → LAUNCH → WAIT → WRITE → (READ | FINISH) → IDLE.
- **IDLE.** On `go`:
  - index ← 0, `best_dist` ← 12'hFFF, `best_idx` ← 0, `timeout_err` ← 0.
  - `busy` ← 1; go to READ.
- **READ.** `pop_re`=1, `pop_addr`=index.
- **CAPTURE.** Register `pop_data` into `dist_in`.
- **LAUNCH.** `dist_start`=1 for exactly this cycle; clear the wait counter.
- **WAIT.**
  - Counter increments each cycle.
  - On `dist_done`, latch `dist_out` and go to WRITE.
  - If the counter reaches TIMEOUT-1 without `dist_done`: latch 12'hFFF, set `timeout_err`, go to WRITE.
  - `dist_done` on the expiry cycle wins; no error is flagged.
- **WRITE.**
  - `fit_we`=1, `fit_addr`=index, `fit_data`=latched value.
  - If the value is strictly less than `best_dist`, update `best_dist` and `best_idx`. Ties keep the lower index.
  - If index = POP_SIZE-1, go to FINISH; otherwise index+1, go to READ.
- **FINISH.** `done`=1 for one cycle, `busy`←0, go to IDLE.
- `dist_in` is held stable from CAPTURE through WRITE.
- `dist_done` outside WAIT is ignored.
- `best_idx`, `best_dist` and `timeout_err` hold their values after FINISH until the next accepted `go`.

## Timing
- Reset values:
  - `pop_re`, `dist_start`, `fit_we`, `busy`, `done`, `timeout_err` = 0.
  - `pop_addr`, `fit_addr`, `best_idx` = 0; `dist_in` = 0; `best_dist` = 12'hFFF.
  - State = IDLE.
- Reset mid-sweep: the next cycle is IDLE with reset values. No `done` pulse, no further `fit_we`.
- Per chromosome: 4 + D cycles, where D = cycles from `dist_start` to `dist_done` (D ≥ 1).
- `go` at cycle 0:
  - `pop_re` at cycle 1.
  - `dist_start` at cycle 3.
  - The first `fit_we` follows `dist_done` by 1 cycle.
- `done` comes 1 cycle after the last `fit_we`.
- `go` during `busy`, including the FINISH cycle, is dropped.
- Index counter never wraps: it stops at POP_SIZE-1.

## Structure
- Shared package `ga_pkg`:
  - `GENE_W`=10, `GENES`=15, `CHROM_W`=150, `DIST_W`=12.
  - `DIST_MAX`=12'hFFF.
  - FSM state enum `sweep_state_t`.
- Optional sub-module `min_tracker`: compare/update of `best_dist`/`best_idx` with clear and strict-less-than rule.
- `CompDistance` is instantiated by the parent, not inside this block.

## Test plan
- **Nominal sweep.** POP_SIZE=4, bench model replies `dist_done` after 5 cycles with distances 300, 120, 120, 450.
  - Four `fit_we` writes with those values at addresses 0..3.
  - `best_idx`=1, `best_dist`=120.
  - One `done` pulse 37 cycles after `go`.
- **Timeout.** Model never answers chromosome 2, TIMEOUT=16.
  - `fit_data`=12'hFFF at address 2.
  - `timeout_err`=1; the sweep completes.
- **Edge-case handshakes.**
  - `dist_done` on exactly the expiry cycle: value 77 is written and `timeout_err` stays 0.
  - Spurious `dist_done` during READ: ignored.
- **Reset mid-sweep.** `rst` in WAIT of chromosome 1.
  - Next cycle: `busy`=0, `best_dist`=12'hFFF, no further writes.
  - A new `go` restarts at address 0.
- **Dropped `go`.** `go` pulsed every cycle for the whole sweep: exactly one sweep runs, and `dist_start` pulses exactly POP_SIZE times, each 1 cycle wide.
- **Chromosome passthrough.** Chromosome 3 = the gene pattern 10'b0000000110 repeated 15 times: `dist_in` equals it bit-exactly from `dist_start` until the matching `fit_we`.
